// File: rtl/demux_1to2_reg.sv
// -----------------------------------------------------------------------------
// demux_1to2_reg
//
// Registered 1-to-2 bus demultiplexer. One source word per cycle is steered to
// destination A (in_sel=0) or B (in_sel=1). Each destination has a one-entry
// holding register, so a stalled consumer blocks only the words addressed to it
// and never causes data loss.
//
// Optional build feature: define DEMUX_STATS_EN to add per-destination
// saturating drain counters (stats_clr, a_count, b_count).
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_data    in   WIDTH  source word
//   in_sel     in   1      destination select (0 = A, 1 = B)
//   in_valid   in   1      source word valid
//   in_ready   out  1      word accepted this cycle (combinational)
//   a_data     out  WIDTH  destination A word (registered)
//   a_valid    out  1      destination A holding register full
//   a_ready    in   1      destination A consumes this cycle
//   b_data     out  WIDTH  destination B word (registered)
//   b_valid    out  1      destination B holding register full
//   b_ready    in   1      destination B consumes this cycle
//   stats_clr  in   1      [DEMUX_STATS_EN] synchronous clear of both counters
//   a_count    out  16     [DEMUX_STATS_EN] completed A drains (saturating)
//   b_count    out  16     [DEMUX_STATS_EN] completed B drains (saturating)
// -----------------------------------------------------------------------------
module demux_1to2_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready
`ifdef DEMUX_STATS_EN
   ,input  logic             stats_clr,
    output logic [15:0]      a_count,
    output logic [15:0]      b_count
`endif
);

    logic [WIDTH-1:0] a_data_r;
    logic [WIDTH-1:0] b_data_r;
    logic             a_valid_r;
    logic             b_valid_r;
    logic             in_ready_s;
    logic             a_load_s;
    logic             b_load_s;
    logic             a_drain_s;
    logic             b_drain_s;

    // Acceptance depends only on the selected destination having room
    // (empty, or being drained this cycle); in_valid does not enter.
    always_comb begin
        in_ready_s = 1'b0;
        if (in_sel == 1'b1) begin
            in_ready_s = (~b_valid_r) | b_ready;
        end else begin
            in_ready_s = (~a_valid_r) | a_ready;
        end
    end

    // Per-destination load and drain qualifiers.
    always_comb begin
        a_load_s  = in_valid & in_ready_s & (~in_sel);
        b_load_s  = in_valid & in_ready_s & in_sel;
        a_drain_s = a_valid_r & a_ready;
        b_drain_s = b_valid_r & b_ready;
    end

    // Destination A holding register: a load wins over a drain, so a
    // simultaneous drain+load replaces the word and stays full. Data is
    // held (not cleared) after a drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid_r <= 1'b0;
            a_data_r  <= {WIDTH{1'b0}};
        end else if (a_load_s) begin
            a_valid_r <= 1'b1;
            a_data_r  <= in_data;
        end else if (a_drain_s) begin
            a_valid_r <= 1'b0;
        end else begin
            a_valid_r <= a_valid_r;
        end
    end

    // Destination B holding register, same policy as A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_valid_r <= 1'b0;
            b_data_r  <= {WIDTH{1'b0}};
        end else if (b_load_s) begin
            b_valid_r <= 1'b1;
            b_data_r  <= in_data;
        end else if (b_drain_s) begin
            b_valid_r <= 1'b0;
        end else begin
            b_valid_r <= b_valid_r;
        end
    end

    // Output mapping.
    always_comb begin
        in_ready = in_ready_s;
        a_data   = a_data_r;
        a_valid  = a_valid_r;
        b_data   = b_data_r;
        b_valid  = b_valid_r;
    end

`ifdef DEMUX_STATS_EN
    logic [15:0] a_count_r;
    logic [15:0] b_count_r;

    // Drain counter for A: clear has priority, then saturating increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_count_r <= 16'h0000;
        end else if (stats_clr) begin
            a_count_r <= 16'h0000;
        end else if (a_drain_s && (a_count_r != 16'hFFFF)) begin
            a_count_r <= a_count_r + 16'h0001;
        end else begin
            a_count_r <= a_count_r;
        end
    end

    // Drain counter for B: clear has priority, then saturating increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_count_r <= 16'h0000;
        end else if (stats_clr) begin
            b_count_r <= 16'h0000;
        end else if (b_drain_s && (b_count_r != 16'hFFFF)) begin
            b_count_r <= b_count_r + 16'h0001;
        end else begin
            b_count_r <= b_count_r;
        end
    end

    // Counter output mapping.
    always_comb begin
        a_count = a_count_r;
        b_count = b_count_r;
    end
`endif

endmodule

// File: tb/tb_demux_1to2_reg.sv
// -----------------------------------------------------------------------------
// tb_demux_1to2_reg
//
// Self-checking bench for demux_1to2_reg. A per-destination scoreboard queue
// receives each word the bench model expects to be accepted; words are popped
// and compared when the model expects the destination to drain. Handshake
// outputs are compared against the bench's own model every cycle.
// -----------------------------------------------------------------------------
module tb_demux_1to2_reg;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_data;
    logic        a_valid;
    logic        a_ready;
    logic [15:0] b_data;
    logic        b_valid;
    logic        b_ready;
`ifdef DEMUX_STATS_EN
    logic        stats_clr;
    logic [15:0] a_count;
    logic [15:0] b_count;
    logic [15:0] exp_a_cnt;
    logic [15:0] exp_b_cnt;
`endif

    int n_checks;
    int n_pass;
    logic [15:0] qa[$];
    logic [15:0] qb[$];

    demux_1to2_reg #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready)
`ifdef DEMUX_STATS_EN
       ,.stats_clr(stats_clr),
        .a_count  (a_count),
        .b_count  (b_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at the negedge, check #1 later, advance to next negedge.
    task automatic cycle(input logic v, input logic s, input logic [15:0] d,
                         input logic ar, input logic br);
        logic        exp_rdy;
        logic [15:0] w;
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        a_ready  = ar;
        b_ready  = br;
        #1;
        exp_rdy = s ? ((qb.size() == 0) || br) : ((qa.size() == 0) || ar);
        check_val("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        check_val("a_valid", {31'd0, a_valid}, {31'd0, (qa.size() != 0)});
        check_val("b_valid", {31'd0, b_valid}, {31'd0, (qb.size() != 0)});
`ifdef DEMUX_STATS_EN
        check_val("a_count", {16'd0, a_count}, {16'd0, exp_a_cnt});
        check_val("b_count", {16'd0, b_count}, {16'd0, exp_b_cnt});
`endif
        if (qa.size() != 0) begin
            if (ar) begin
                w = qa.pop_front();
                check_val("a_drain_data", {16'd0, a_data}, {16'd0, w});
`ifdef DEMUX_STATS_EN
                if (!stats_clr && exp_a_cnt != 16'hFFFF) exp_a_cnt = exp_a_cnt + 16'd1;
`endif
            end else begin
                check_val("a_hold_data", {16'd0, a_data}, {16'd0, qa[0]});
            end
        end
        if (qb.size() != 0) begin
            if (br) begin
                w = qb.pop_front();
                check_val("b_drain_data", {16'd0, b_data}, {16'd0, w});
`ifdef DEMUX_STATS_EN
                if (!stats_clr && exp_b_cnt != 16'hFFFF) exp_b_cnt = exp_b_cnt + 16'd1;
`endif
            end else begin
                check_val("b_hold_data", {16'd0, b_data}, {16'd0, qb[0]});
            end
        end
`ifdef DEMUX_STATS_EN
        if (stats_clr) begin
            exp_a_cnt = 16'd0;
            exp_b_cnt = 16'd0;
        end
`endif
        if (v && exp_rdy) begin
            if (s) qb.push_back(d);
            else   qa.push_back(d);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sel   = 1'b0;
        in_data  = 16'h0000;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
`ifdef DEMUX_STATS_EN
        stats_clr = 1'b0;
        exp_a_cnt = 16'd0;
        exp_b_cnt = 16'd0;
`endif
        repeat (2) @(negedge clk);
        // Reset state
        check_val("rst_a_valid", {31'd0, a_valid}, 32'd0);
        check_val("rst_b_valid", {31'd0, b_valid}, 32'd0);
        check_val("rst_a_data", {16'd0, a_data}, 32'd0);
        check_val("rst_b_data", {16'd0, b_data}, 32'd0);
        check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single word to A, one-cycle latency, then empty
        cycle(1'b1, 1'b0, 16'hF0F0, 1'b1, 1'b0);
        check_val("t1_a_data", {16'd0, a_data}, 32'h0000F0F0);
        cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

        // 2: B fills, second B word stalls until b_ready
        cycle(1'b1, 1'b1, 16'h0F0F, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0);
            check_val("t2_b_held", {16'd0, b_data}, 32'h00000F0F);
        end
        cycle(1'b1, 1'b1, 16'h1234, 1'b0, 1'b1);
        check_val("t2_b_new", {16'd0, b_data}, 32'h00001234);

        // 3: B stalled full, A streams freely
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, 1'b0, 16'(i), 1'b1, 1'b0);
        end
        cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

        // 4: A full and draining while a new A word arrives
        cycle(1'b1, 1'b0, 16'h5555, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 16'hBEEF, 1'b1, 1'b0);
        check_val("t4_a_data", {16'd0, a_data}, 32'h0000BEEF);
        cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 16'h0000, 1'b1, 1'b1);

        // Random mix
        for (int i = 0; i < 60; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

        // 5: asynchronous reset with both registers full
        cycle(1'b1, 1'b0, 16'hAAAA, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 16'hBBBB, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t5_a_valid", {31'd0, a_valid}, 32'd0);
        check_val("t5_b_valid", {31'd0, b_valid}, 32'd0);
        check_val("t5_a_data", {16'd0, a_data}, 32'd0);
        check_val("t5_b_data", {16'd0, b_data}, 32'd0);
        qa.delete();
        qb.delete();
`ifdef DEMUX_STATS_EN
        exp_a_cnt = 16'd0;
        exp_b_cnt = 16'd0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

`ifdef DEMUX_STATS_EN
        // 6: drain counters
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'(i), 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 16'(i), 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        check_val("t6_a_count", {16'd0, a_count}, 32'd3);
        check_val("t6_b_count", {16'd0, b_count}, 32'd2);
        cycle(1'b1, 1'b0, 16'h7777, 1'b1, 1'b1);
        stats_clr = 1'b1;
        cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        stats_clr = 1'b0;
        check_val("t6_clr_a_count", {16'd0, a_count}, 32'd0);
        for (int i = 0; i < 65536; i++) cycle(1'b1, 1'b1, 16'(i), 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 16'h0000, 1'b1, 1'b1);
        check_val("t6_b_sat", {16'd0, b_count}, 32'h0000FFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/demux_1to2_reg.md
Name: demux_1to2_reg

Overview:
- Registered 1-to-2 bus demultiplexer; the routing counterpart of the 2-to-1 datapath mux.
- Steers one WIDTH-bit source word to one of two destinations (A or B) per `sel`.
- Uses valid/ready handshakes and a one-entry holding register per destination.
- Sits between the ALU/writeback result bus and two consumers (e.g. register-file write port and memory store path) so one stalled consumer never drops data.

Parameters:
- WIDTH, 16, data word width in bits.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  source word.
- in_sel  input  1  destination select: 0 = A, 1 = B.
- in_valid  input  1  source word valid.
- in_ready  output  1  block accepts word this cycle.
- a_data  output  WIDTH  destination A word (registered).
- a_valid  output  1  destination A holding register full.
- a_ready  input  1  destination A consumes this cycle.
- b_data  output  WIDTH  destination B word (registered).
- b_valid  output  1  destination B holding register full.
- b_ready  input  1  destination B consumes this cycle.

Behaviour:
- Reset (rst_n low, asynchronous): a_valid=0, b_valid=0, a_data=0, b_data=0. in_ready follows its combinational equation, so it reads 1 while both registers are empty.
- Per-destination state: EMPTY (x_valid=0) or FULL (x_valid=1).
- Transitions:
  - EMPTY->FULL on load.
  - FULL->EMPTY on drain without load.
  - FULL->FULL on simultaneous drain+load, where the new word replaces the old.
- Drain of X: x_valid & x_ready at the rising edge.
- Load of X: in_valid & in_ready & (in_sel selects X) at the rising edge. x_data <= in_data and x_valid <= 1 on that edge.
- in_ready is combinational:
  - in_sel=0: in_ready = !a_valid | a_ready.
  - in_sel=1: in_ready = !b_valid | b_ready.
  - in_ready does not depend on in_valid.
- Latency: a word accepted at edge N is presented on x_data/x_valid after edge N, one cycle.
- Throughput: one word per cycle to a continuously-ready destination.
- The non-selected destination is unaffected by input activity. It can drain in the same cycle the other one loads.
- Stall isolation: B full with b_ready=0 blocks only words with in_sel=1. Words with in_sel=0 flow freely.
- x_data is stable while x_valid=1 and x_ready=0. x_data is held (not cleared) after drain.
- in_sel is sampled only when in_valid=1. It is don't-care otherwise.
- Ordering: words to the same destination leave in acceptance order. There is no ordering guarantee between A and B.
- No data loss and no duplication: each accepted word appears exactly once on exactly one destination.
- Reset mid-operation: any held words are discarded and the block returns to the reset values immediately.
- A source that holds in_valid with stable in_data/in_sel until in_ready is supported. The block does not require it.

Optional Feature:
- Macro: DEMUX_STATS_EN.
- With the macro defined, these ports are added:
  - stats_clr  input  1  synchronous clear of both counters.
  - a_count  output  16  completed A drains.
  - b_count  output  16  completed B drains.
- Counter behaviour:
  - Each counter increments by 1 per drain of its destination.
  - Counters saturate at 16'hFFFF.
  - Reset value is 0.
  - stats_clr has priority over a same-cycle increment.
- Without the macro: the three ports and all counter logic are absent. Handshake and data behaviour are identical either way.

Test Plan:
1. Reset, then in_valid=1, in_sel=0, in_data=16'hF0F0, a_ready=1 for one cycle -> a_valid=1 with a_data=16'hF0F0 one cycle later; b_valid stays 0; a_valid returns to 0 the next cycle.
2. in_sel=1, in_data=16'h0F0F, b_ready=0 -> b_valid=1, b_data=16'h0F0F. A second in_sel=1 word 16'h1234 sees in_ready=0 until b_ready=1, and b_data holds 16'h0F0F throughout the stall.
3. B stalled full (b_ready=0); stream 16'h0001..16'h0004 with in_sel=0, a_ready=1 -> in_ready=1 each cycle and A outputs 0001,0002,0003,0004 in consecutive cycles.
4. A full with a_ready=1; new in_sel=0 word 16'hBEEF in the same cycle -> a_valid stays 1, a_data becomes 16'hBEEF, and the old word counts as drained exactly once.
5. Both registers full (A=16'hAAAA, B=16'hBBBB), assert rst_n=0 mid-cycle -> a_valid=b_valid=a_data=b_data=0 immediately, without waiting for clk.
6. DEMUX_STATS_EN defined:
   - 3 A drains and 2 B drains -> a_count=3, b_count=2.
   - stats_clr together with an A drain -> a_count=0.
   - Force 65535 B drains, then one more -> b_count holds 16'hFFFF.
